// File: rtl/eth_rx_frame_arb.sv
// Frame-atomic round-robin arbiter sharing one RX byte bus between N_SRC sources.
// Grants whole frames, inserts an inter-frame gap and cuts frames longer than MAX_FRAME.
module eth_rx_frame_arb #(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MAX_FRAME  = 1526
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [8*N_SRC-1:0]         src_byte,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC-1:0]           src_last,
  output logic [N_SRC-1:0]           src_ready,
  output logic [7:0]                 out_byte,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic                       busy,
  output logic                       trunc_pulse
);

  localparam int unsigned GW       = $clog2(N_SRC);
  localparam int unsigned CW       = $clog2(MAX_FRAME + 1);
  localparam int unsigned PW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

  localparam state_t END_ST = (IFG_CYCLES == 0) ? IDLE : GAP;

  state_t          state, state_d;
  logic [GW-1:0]   rr_ptr, rr_ptr_d, grant_d, pick, idx, nxt_ptr;
  logic [CW-1:0]   byte_cnt, cnt_d;
  logic [PW-1:0]   gap_cnt, gap_d;
  logic            trunc_d, found, sel_valid, sel_last, at_max;

  assign sel_valid = src_valid[grant_id];
  assign sel_last  = src_last[grant_id];
  assign at_max    = (byte_cnt == CW'(MAX_FRAME - 1));
  assign nxt_ptr   = GW'((32'(grant_id) + 32'd1) % N_SRC);
  assign busy      = (state != IDLE);

  // First requesting source at or after rr_ptr, wrapping modulo N_SRC
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = GW'((32'(rr_ptr) + k) % N_SRC);
      if (!found && src_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    rr_ptr_d  = rr_ptr;
    grant_d   = grant_id;
    cnt_d     = byte_cnt;
    gap_d     = gap_cnt;
    trunc_d   = 1'b0;
    src_ready = '0;
    out_byte  = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        out_byte            = src_byte[{grant_id, 3'b000} +: 8];
        out_valid           = sel_valid;
        out_last            = sel_last | at_max;
        src_ready[grant_id] = out_ready;
        if (sel_valid && out_ready) begin
          cnt_d = byte_cnt + CW'(1);
          if (sel_last) begin
            rr_ptr_d = nxt_ptr;
            state_d  = END_ST;
          end else if (at_max) begin
            // Cut here; the rest of the source frame is swallowed in DRAIN
            rr_ptr_d = nxt_ptr;
            trunc_d  = 1'b1;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        src_ready[grant_id] = 1'b1;
        if (sel_valid && sel_last) state_d = END_ST;
      end
      GAP: begin
        if (gap_cnt == PW'(GAP_LAST)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_cnt + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      trunc_pulse <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      grant_id    <= grant_d;
      byte_cnt    <= cnt_d;
      gap_cnt     <= gap_d;
      trunc_pulse <= trunc_d;
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_arb.sv
// Scoreboard bench for eth_rx_frame_arb: per-source frame queues feed the DUT, a frame-level
// round-robin model predicts the forwarded byte stream, and a negedge monitor checks it.
module tb_eth_rx_frame_arb;

  localparam int unsigned N    = 4;
  localparam int unsigned IFG  = 12;
  localparam int unsigned MAXF = 8;

  typedef struct {
    int         src;
    logic [7:0] b;
    logic       last;
    logic       trunc;
    logic       first;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [8*N-1:0]   src_byte;
  logic [N-1:0]     src_valid;
  logic [N-1:0]     src_last;
  logic [N-1:0]     src_ready;
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic [1:0]       grant_id;
  logic             busy;
  logic             trunc_pulse;

  eth_rx_frame_arb #(.N_SRC(N), .IFG_CYCLES(IFG), .MAX_FRAME(MAXF)) dut (
    .clk(clk), .rst_n(rst_n), .src_byte(src_byte), .src_valid(src_valid),
    .src_last(src_last), .src_ready(src_ready), .out_byte(out_byte),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .trunc_pulse(trunc_pulse)
  );

  always #5 clk = ~clk;

  logic [8:0] srcq [N][$];
  logic [8:0] mq   [N][$];
  exp_t       expq [$];
  int         gseq [$];
  int         mptr = 0;
  int         checks = 0, passed = 0;
  int         exp_trunc = 0, trunc_seen = 0, xfer_cnt = 0;
  int         ready_mode = 0;
  bit         bubble_en = 0;
  bit         trunc_pend = 0;
  logic [N-1:0] hs = '0;
  bit         mid [N];
  int         hold [N];
  int         fpos [N];
  int         hold_after [N];
  logic [8:0] drv_ent;
  exp_t       mon_e;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic push_byte(input int s, input logic [7:0] b, input logic last);
    srcq[s].push_back({last, b});
    mq[s].push_back({last, b});
  endtask

  task automatic add_frame(input int s, input int len);
    for (int k = 1; k <= len; k++) push_byte(s, 8'($urandom), k == len);
  endtask

  // Reference: whole frames granted round-robin among sources with queued frames
  task automatic plan();
    int g, k;
    logic [8:0] ent;
    exp_t e;
    forever begin
      g = -1;
      for (int j = 0; j < N; j++) begin
        int s;
        s = (mptr + j) % N;
        if (g < 0 && mq[s].size() > 0) g = s;
      end
      if (g < 0) break;
      k = 0;
      do begin
        ent = mq[g].pop_front();
        k++;
        if (k <= MAXF) begin
          e.src = g; e.b = ent[7:0]; e.first = (k == 1);
          e.last = ent[8] || (k == MAXF);
          e.trunc = (k == MAXF) && !ent[8];
          if (e.trunc) exp_trunc++;
          expq.push_back(e);
        end
      end while (!ent[8]);
      mptr = (g + 1) % N;
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < N; i++) n += srcq[i].size();
    return n;
  endfunction

  task automatic run_phase(input string name);
    int n = 0;
    while ((pending() != 0 || busy || expq.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 5000, {name, "_timeout"}, 32'(n), 32'd5000);
    chk(expq.size() == 0, {name, "_leftover"}, 32'(expq.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Source models and downstream ready generator
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        mid[i] = 0; hold[i] = 0; fpos[i] = 0;
      end else if (hs[i] && srcq[i].size() > 0) begin
        drv_ent = srcq[i].pop_front();
        mid[i]  = !drv_ent[8];
        fpos[i] = mid[i] ? fpos[i] + 1 : 0;
        if (mid[i] && fpos[i] == hold_after[i]) hold[i] = 3;
        else if (mid[i] && bubble_en && $urandom_range(0, 3) == 0) hold[i] = $urandom_range(1, 3);
      end
      if (hold[i] > 0) begin
        src_valid[i] = 1'b0; src_last[i] = 1'b0; src_byte[8*i +: 8] = 8'($urandom);
        hold[i]--;
      end else if (srcq[i].size() > 0) begin
        src_valid[i] = 1'b1; src_last[i] = srcq[i][0][8]; src_byte[8*i +: 8] = srcq[i][0][7:0];
      end else begin
        src_valid[i] = 1'b0; src_last[i] = 1'b0; src_byte[8*i +: 8] = 8'h00;
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every accepted output byte
  always @(negedge clk) begin
    hs = src_valid & src_ready;
    if (!rst_n) begin
      trunc_pend = 0;
    end else begin
      chk(($countones(src_ready) <= 1) && (busy || (src_ready == '0 && !out_valid)),
          "ready_quiet", 32'({busy, out_valid, src_ready}), 32'({busy, 1'b0, 4'h0}));
      if (trunc_pend || trunc_pulse)
        chk(trunc_pulse == trunc_pend, "trunc_pulse", 32'(trunc_pulse), 32'(trunc_pend));
      if (trunc_pulse) trunc_seen++;
      trunc_pend = 0;
      if (out_valid && expq.size() > 0)
        chk(src_ready == (out_ready ? N'(1) << expq[0].src : N'(0)), "src_ready_mirror",
            32'(src_ready), 32'(out_ready ? N'(1) << expq[0].src : N'(0)));
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (expq.size() == 0) begin
          chk(1'b0, "unexpected_byte", 32'({grant_id, out_last, out_byte}), 32'd0);
        end else begin
          mon_e = expq.pop_front();
          chk({grant_id, out_last, out_byte} == {2'(mon_e.src), mon_e.last, mon_e.b}, "out_byte",
              32'({grant_id, out_last, out_byte}), 32'({2'(mon_e.src), mon_e.last, mon_e.b}));
          if (mon_e.first) gseq.push_back(int'(grant_id));
          trunc_pend = mon_e.trunc;
        end
      end
    end
  end

  initial begin
    int n, base;
    int order1 [6] = '{0, 1, 3, 0, 1, 3};
    int order2 [3] = '{2, 3, 0};
    for (int i = 0; i < N; i++) hold_after[i] = -1;
    rst_n = 1'b0;
    #12;
    chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
    chk(out_last == 1'b0, "rst_out_last", 32'(out_last), 32'd0);
    chk(out_byte == 8'h00, "rst_out_byte", 32'(out_byte), 32'd0);
    chk(src_ready == '0, "rst_src_ready", 32'(src_ready), 32'd0);
    chk(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
    chk(grant_id == 2'd0, "rst_grant_id", 32'(grant_id), 32'd0);
    chk(trunc_pulse == 1'b0, "rst_trunc", 32'(trunc_pulse), 32'd0);
    #10 rst_n = 1'b1;

    // Single 8-byte frame ending exactly at MAX_FRAME: 1 arb + 8 bytes + 12 gap cycles
    @(negedge clk);
    for (int k = 0; k < 6; k++) push_byte(0, 8'h55, 1'b0);
    push_byte(0, 8'hD5, 1'b0);
    push_byte(0, 8'h01, 1'b1);
    plan();
    n = 0;
    while (!src_valid[0] && n < 10) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 100);
    chk(n == 1 + 8 + IFG, "frame_latency", 32'(n), 32'(1 + 8 + IFG));
    run_phase("single");

    // Reset in the middle of a frame
    add_frame(2, 7);
    plan();
    base = xfer_cnt;
    n = 0;
    while (xfer_cnt < base + 3 && n < 100) begin @(negedge clk); n++; end
    chk(n < 100, "mid_xfer_reach", 32'(n), 32'd100);
    #2 rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0 && out_last == 1'b0 && out_byte == 8'h00, "async_rst_out",
        32'({out_valid, out_last, out_byte}), 32'd0);
    chk(src_ready == '0 && busy == 1'b0, "async_rst_ready", 32'({busy, src_ready}), 32'd0);
    chk(grant_id == 2'd0, "async_rst_grant", 32'(grant_id), 32'd0);
    for (int i = 0; i < N; i++) begin srcq[i].delete(); mq[i].delete(); end
    expq.delete();
    mptr = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Continuous requests from sources 0, 1, 3 restart round-robin from 0
    @(negedge clk);
    gseq.delete();
    for (int r = 0; r < 2; r++) begin add_frame(0, 4); add_frame(1, 4); add_frame(3, 4); end
    plan();
    run_phase("rr");
    chk(gseq.size() == 6, "rr_frames", 32'(gseq.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < gseq.size()) chk(gseq[i] == order1[i], "rr_order", 32'(gseq[i]), 32'(order1[i]));

    // Backpressure toggling every cycle
    ready_mode = 1;
    base = xfer_cnt;
    add_frame(1, 6);
    plan();
    run_phase("toggle");
    chk(xfer_cnt - base == 6, "toggle_count", 32'(xfer_cnt - base), 32'd6);
    ready_mode = 0;

    // Over-long frame is cut, drained, and the next source follows
    gseq.delete();
    base = trunc_seen;
    add_frame(2, 12);
    add_frame(3, 3);
    add_frame(0, 2);
    plan();
    run_phase("trunc");
    chk(trunc_seen - base == 1, "trunc_once", 32'(trunc_seen - base), 32'd1);
    for (int i = 0; i < 3; i++)
      if (i < gseq.size()) chk(gseq[i] == order2[i], "trunc_order", 32'(gseq[i]), 32'(order2[i]));

    // Source 2 stalls 3 cycles mid-frame while source 3 is waiting
    hold_after[2] = 2;
    add_frame(2, 6);
    add_frame(3, 4);
    plan();
    run_phase("bubble");
    hold_after[2] = -1;

    // Randomised traffic with bubbles and random backpressure
    bubble_en  = 1;
    ready_mode = 2;
    for (int f = 0; f < 30; f++) add_frame($urandom_range(0, N - 1), $urandom_range(1, 12));
    plan();
    run_phase("random");
    chk(trunc_seen == exp_trunc, "trunc_total", 32'(trunc_seen), 32'(exp_trunc));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
